// File: rtl/rv_alu_pipe_if.sv
// rv_alu_pipe_if: instruction issue, retire and debug-read signals of the ALU pipe.
// Latency: none, this is wiring only.
// Backpressure: none; the issuer never stalls, and WB outputs are pulses and levels.
interface rv_alu_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(NREGS);

  logic             instr_valid;
  logic [31:0]      instr;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;
  logic [AW-1:0]    dbg_addr;
  logic [XLEN-1:0]  dbg_data;

  // The issuer (fetch or bench) drives instructions and the debug address.
  modport master (
    output instr_valid, instr, dbg_addr,
    input  wb_valid, wb_rd, wb_data, illegal, retired_cnt, dbg_data
  );

  // The pipe consumes instructions and reports retirement.
  modport slave (
    input  instr_valid, instr, dbg_addr,
    output wb_valid, wb_rd, wb_data, illegal, retired_cnt, dbg_data
  );
endinterface

// File: rtl/rv_alu_pipe.sv
// rv_alu_pipe: 3-stage ID/EX/WB R-type integer datapath with full EX/WB forwarding.
// Latency: 2 cycles from accept to WB outputs; the regfile write happens one edge later.
// Backpressure: none; 1 instr/cycle, and instr_valid=0 inserts a bubble.
module rv_alu_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_alu_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam logic [6:0] OPC_OP = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  // EX stage contents: operands are the values read (with bypass) at ID.
  typedef struct packed {
    logic            vld;
    logic            ill;
    alu_op_t         op;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } ex_t;

  logic [XLEN-1:0]  regs [NREGS];
  ex_t              ex_q;
  logic             wb_vld_q;
  logic             wb_ill_q;
  logic [AW-1:0]    wb_rd_q;
  logic [XLEN-1:0]  wb_dat_q;
  logic [CNT_W-1:0] cnt_q;

  logic [6:0]      id_opc;
  logic [6:0]      id_f7;
  logic [2:0]      id_f3;
  logic [AW-1:0]   id_rd;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_legal;
  alu_op_t         id_op;
  logic [XLEN-1:0] id_a;
  logic [XLEN-1:0] id_b;
  logic            wb_fwd;
  logic [XLEN-1:0] ex_opa;
  logic [XLEN-1:0] ex_opb;
  logic [XLEN-1:0] alu_res;

  assign id_opc = bus.instr[6:0];
  assign id_f3  = bus.instr[14:12];
  assign id_f7  = bus.instr[31:25];
  assign id_rd  = bus.instr[7 +: AW];
  assign id_rs1 = bus.instr[15 +: AW];
  assign id_rs2 = bus.instr[20 +: AW];

  // Only a legal retiring instruction with a nonzero rd may feed younger ones.
  assign wb_fwd = wb_vld_q && (wb_rd_q != '0);

  // Decode the opcode and funct7/funct3 pair into an ALU op plus a legality flag.
  always_comb begin
    id_op    = ALU_ADD;
    id_legal = 1'b0;
    if (id_opc == OPC_OP) begin
      id_legal = 1'b1;
      case ({id_f7, id_f3})
        10'b0000000_000: id_op = ALU_ADD;
        10'b0100000_000: id_op = ALU_SUB;
        10'b0000000_001: id_op = ALU_SLL;
        10'b0000000_010: id_op = ALU_SLT;
        10'b0000000_011: id_op = ALU_SLTU;
        10'b0000000_100: id_op = ALU_XOR;
        10'b0000000_101: id_op = ALU_SRL;
        10'b0100000_101: id_op = ALU_SRA;
        10'b0000000_110: id_op = ALU_OR;
        10'b0000000_111: id_op = ALU_AND;
        default:         id_legal = 1'b0;
      endcase
    end
  end

  // Regfile read with write-through of the WB value being written this edge.
  always_comb begin
    id_a = regs[id_rs1];
    id_b = regs[id_rs2];
    if (id_rs1 == '0) id_a = '0;
    else if (wb_fwd && (wb_rd_q == id_rs1)) id_a = wb_dat_q;
    if (id_rs2 == '0) id_b = '0;
    else if (wb_fwd && (wb_rd_q == id_rs2)) id_b = wb_dat_q;
  end

  // Forward the WB result over the ID-latched operand, then evaluate the ALU.
  always_comb begin
    ex_opa = ex_q.a;
    ex_opb = ex_q.b;
    if (wb_fwd && (wb_rd_q == ex_q.rs1)) ex_opa = wb_dat_q;
    if (wb_fwd && (wb_rd_q == ex_q.rs2)) ex_opb = wb_dat_q;
    alu_res = '0;
    case (ex_q.op)
      ALU_ADD:  alu_res = ex_opa + ex_opb;
      ALU_SUB:  alu_res = ex_opa - ex_opb;
      ALU_SLL:  alu_res = ex_opa << ex_opb[SW-1:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex_opa) < $signed(ex_opb))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ex_opa < ex_opb)};
      ALU_XOR:  alu_res = ex_opa ^ ex_opb;
      ALU_SRL:  alu_res = ex_opa >> ex_opb[SW-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(ex_opa) >>> ex_opb[SW-1:0]);
      ALU_OR:   alu_res = ex_opa | ex_opb;
      ALU_AND:  alu_res = ex_opa & ex_opb;
      default:  alu_res = '0;
    endcase
  end

  // ID -> EX register: capture the decoded instruction and its bypassed operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q.vld <= bus.instr_valid;
      ex_q.ill <= ~id_legal;
      ex_q.op  <= id_op;
      ex_q.rd  <= id_rd;
      ex_q.rs1 <= id_rs1;
      ex_q.rs2 <= id_rs2;
      ex_q.a   <= id_a;
      ex_q.b   <= id_b;
    end
  end

  // EX -> WB register: illegal instructions become bubbles that carry the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q <= 1'b0;
      wb_ill_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_dat_q <= '0;
    end else begin
      wb_vld_q <= ex_q.vld & ~ex_q.ill;
      wb_ill_q <= ex_q.vld &  ex_q.ill;
      wb_rd_q  <= ex_q.rd;
      wb_dat_q <= alu_res;
    end
  end

  // Architectural regfile write; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_vld_q && (wb_rd_q != '0)) begin
      regs[wb_rd_q] <= wb_dat_q;
    end
  end

  // Count legal retirements, including those that target x0; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (wb_vld_q) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.wb_valid    = wb_vld_q;
  assign bus.illegal     = wb_ill_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_dat_q;
  assign bus.retired_cnt = cnt_q;
  assign bus.dbg_data    = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];
endmodule

// File: tb/tb_rv_alu_pipe.sv
// tb_rv_alu_pipe: scoreboard bench for rv_alu_pipe at XLEN=32/NREGS=32.
// Latency: each issued instruction is expected on the WB outputs exactly 2 cycles later.
// Backpressure: none; the stimulus issues back-to-back or with bubbles at will.
module tb_rv_alu_pipe;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_SLT  = 10'b0000000_010;
  localparam logic [9:0] F_SLTU = 10'b0000000_011;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_SRL  = 10'b0000000_101;
  localparam logic [9:0] F_SRA  = 10'b0100000_101;
  localparam logic [9:0] F_OR   = 10'b0000000_110;
  localparam logic [9:0] F_AND  = 10'b0000000_111;
  localparam logic [9:0] F_MUL  = 10'b0000001_000;

  typedef struct {
    bit          legal;
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mcnt = 0;
  logic [31:0] mregs [32];
  exp_t sb [$];
  exp_t mon_e;

  rv_alu_pipe_if #(.XLEN(32), .NREGS(32), .CNT_W(32)) bus ();
  rv_alu_pipe #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input logic [9:0] f, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [6:0] opc);
    return {f[9:3], rs2, rs1, f[2:0], rd, opc};
  endfunction

  // Architectural reference: sequential semantics on the model regfile.
  task automatic model(input logic [31:0] ins, output bit legal, output logic [31:0] v);
    logic [31:0] a, b;
    logic [4:0]  sh;
    a = mregs[ins[19:15]];
    b = mregs[ins[24:20]];
    sh = b[4:0];
    legal = 1'b1;
    v = 32'h0;
    if (ins[6:0] != OPC_OP) legal = 1'b0;
    else begin
      case ({ins[31:25], ins[14:12]})
        F_ADD:   v = a + b;
        F_SUB:   v = a - b;
        F_SLL:   v = a << sh;
        F_SLT:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        F_SLTU:  v = (a < b) ? 32'd1 : 32'd0;
        F_XOR:   v = a ^ b;
        F_SRL:   v = a >> sh;
        F_SRA:   v = $unsigned($signed(a) >>> sh);
        F_OR:    v = a | b;
        F_AND:   v = a & b;
        default: legal = 1'b0;
      endcase
    end
  endtask

  // Present one instruction for one cycle and schedule its expected retirement.
  task automatic issue(input logic [31:0] ins);
    exp_t e;
    bit   lg;
    logic [31:0] v;
    model(ins, lg, v);
    e.legal = lg;
    e.rd    = ins[11:7];
    e.data  = v;
    e.due   = cyc + 2;
    if (lg && (ins[11:7] != 5'd0)) mregs[ins[11:7]] = v;
    sb.push_back(e);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Backdoor preload while the pipe is empty; there is no immediate-op path.
  task automatic poke(input int r, input logic [31:0] v);
    dut.regs[r] = v;
    mregs[r] = v;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    bus.dbg_addr = r;
    #1;
    check(tag, {32'h0, bus.dbg_data}, {32'h0, exp});
  endtask

  // Pop the scoreboard on every retirement and flag missing or spurious outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_valid || bus.illegal) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 64'(cyc), 64'(mon_e.due));
          check("wb_valid", {63'h0, bus.wb_valid}, {63'h0, mon_e.legal});
          check("illegal", {63'h0, bus.illegal}, {63'h0, !mon_e.legal});
          if (mon_e.legal) begin
            check("wb_rd", {59'h0, bus.wb_rd}, {59'h0, mon_e.rd});
            check("wb_data", {32'h0, bus.wb_data}, {32'h0, mon_e.data});
            check("retired_cnt", {32'h0, bus.retired_cnt}, 64'(mcnt));
            mcnt++;
          end
        end
      end else if ((sb.size() > 0) && (sb[0].due <= cyc)) begin
        mon_e = sb.pop_front();
        check("missing_out", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus.dbg_addr = 5'd0;

    // Reset state
    #1;
    check("rst_wb_valid", {63'h0, bus.wb_valid}, 64'd0);
    check("rst_illegal", {63'h0, bus.illegal}, 64'd0);
    check("rst_wb_rd", {59'h0, bus.wb_rd}, 64'd0);
    check("rst_wb_data", {32'h0, bus.wb_data}, 64'd0);
    check("rst_cnt", {32'h0, bus.retired_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // 1: zero-source ADDs
    issue(enc(F_ADD, 5'd1, 5'd0, 5'd0, OPC_OP));
    issue(enc(F_ADD, 5'd2, 5'd0, 5'd0, OPC_OP));
    issue(enc(F_ADD, 5'd3, 5'd0, 5'd0, OPC_OP));
    idle(4);
    check("t1_cnt", {32'h0, bus.retired_cnt}, 64'd3);
    chk_reg("t1_x1", 5'd1, 32'h0);

    // 2: back-to-back chain via EX forward and ID bypass
    poke(2, 32'd5);
    poke(4, 32'd1);
    issue(enc(F_SUB, 5'd1, 5'd0, 5'd2, OPC_OP));
    issue(enc(F_SRA, 5'd3, 5'd1, 5'd4, OPC_OP));
    issue(enc(F_SRL, 5'd5, 5'd1, 5'd4, OPC_OP));
    idle(4);
    chk_reg("t2_x1", 5'd1, 32'hFFFF_FFFB);
    chk_reg("t2_x3", 5'd3, 32'hFFFF_FFFD);
    chk_reg("t2_x5", 5'd5, 32'h7FFF_FFFD);

    // 3: compares, wrap, remaining ops, distance-3 dependence
    poke(1, 32'hFFFF_FFFF);
    poke(2, 32'd1);
    poke(8, 32'h7FFF_FFFF);
    poke(14, 32'h23);
    issue(enc(F_SLT,  5'd6,  5'd1, 5'd2,  OPC_OP));
    issue(enc(F_SLTU, 5'd7,  5'd1, 5'd2,  OPC_OP));
    issue(enc(F_ADD,  5'd9,  5'd8, 5'd2,  OPC_OP));
    issue(enc(F_XOR,  5'd10, 5'd1, 5'd8,  OPC_OP));
    issue(enc(F_OR,   5'd11, 5'd2, 5'd8,  OPC_OP));
    issue(enc(F_AND,  5'd12, 5'd9, 5'd1,  OPC_OP));
    issue(enc(F_SLL,  5'd15, 5'd2, 5'd14, OPC_OP));
    issue(enc(F_SRA,  5'd16, 5'd9, 5'd4,  OPC_OP));
    issue(enc(F_ADD,  5'd17, 5'd12, 5'd0, OPC_OP));
    idle(4);
    chk_reg("t3_slt", 5'd6, 32'd1);
    chk_reg("t3_sltu", 5'd7, 32'd0);
    chk_reg("t3_wrap", 5'd9, 32'h8000_0000);
    chk_reg("t3_sll", 5'd15, 32'd8);
    chk_reg("t3_dist3", 5'd17, 32'h8000_0000);

    // 4: illegal ops between legal ones leave the old value visible
    poke(21, 32'd9);
    cnt0 = mcnt;
    issue(enc(F_ADD, 5'd22, 5'd2, 5'd2, OPC_OP));
    issue(enc(F_ADD, 5'd21, 5'd2, 5'd2, OPC_IMM));
    issue(enc(F_ADD, 5'd23, 5'd21, 5'd0, OPC_OP));
    issue(enc(F_MUL, 5'd21, 5'd2, 5'd2, OPC_OP));
    issue(enc(F_ADD, 5'd24, 5'd21, 5'd0, OPC_OP));
    idle(4);
    check("t4_cnt_delta", 64'(bus.retired_cnt) - 64'(cnt0), 64'd3);
    chk_reg("t4_x21", 5'd21, 32'd9);
    chk_reg("t4_x23", 5'd23, 32'd9);
    chk_reg("t4_x24", 5'd24, 32'd9);

    // 5: rd=x0 retires but never writes or forwards
    poke(1, 32'd3);
    poke(2, 32'd4);
    issue(enc(F_ADD, 5'd0,  5'd1, 5'd2, OPC_OP));
    issue(enc(F_ADD, 5'd25, 5'd0, 5'd1, OPC_OP));
    issue(enc(F_OR,  5'd26, 5'd0, 5'd0, OPC_OP));
    idle(4);
    chk_reg("t5_x0", 5'd0, 32'h0);
    chk_reg("t5_x25", 5'd25, 32'd3);
    chk_reg("t5_x26", 5'd26, 32'd0);

    // 6: reset with two instructions in flight
    issue(enc(F_ADD, 5'd27, 5'd1, 5'd2, OPC_OP));
    issue(enc(F_ADD, 5'd28, 5'd1, 5'd2, OPC_OP));
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt = 0;
    #1;
    check("t6_wb_valid", {63'h0, bus.wb_valid}, 64'd0);
    check("t6_cnt", {32'h0, bus.retired_cnt}, 64'd0);
    chk_reg("t6_x1", 5'd1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    chk_reg("t6_x27", 5'd27, 32'h0);
    chk_reg("t6_x28", 5'd28, 32'h0);
    check("t6_cnt_after", {32'h0, bus.retired_cnt}, 64'd0);

    // A short post-reset sanity op
    poke(3, 32'h1234_5678);
    issue(enc(F_XOR, 5'd4, 5'd3, 5'd3, OPC_OP));
    issue(enc(F_SUB, 5'd5, 5'd4, 5'd3, OPC_OP));
    idle(4);
    chk_reg("post_x5", 5'd5, 32'hEDCB_A988);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
